// File: rtl/bcd_digit_serializer.sv
// rtl/bcd_digit_serializer.sv - packed-BCD snapshot streamed MSD-first as ASCII over valid/ready
module bcd_digit_serializer #(
    parameter int DIGITS_NUM          = 6,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    output logic                    busy_out,
    output logic [7:0]              char_out,
    output logic                    char_valid_out,
    input  logic                    char_ready_in,
    output logic                    char_last_out,
    output logic                    done_out,
    output logic                    digit_error_out
);

    localparam int                IDX_W      = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(DIGITS_NUM - 1);
    localparam logic              BLANK_INIT = (BLANK_LEADING_ZEROS != 0);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [4*DIGITS_NUM-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    blank_q, blank_d;
    logic                    err_q, err_d;
    logic [7:0]              char_q, char_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;

    logic [IDX_W-1:0]        next_idx;
    logic [3:0]              nib;
    logic [8:0]              enc;

    function automatic logic [3:0] pick_nibble(input logic [4*DIGITS_NUM-1:0] v,
                                               input logic [IDX_W-1:0] i);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < DIGITS_NUM; k++) begin
            if (i == IDX_W'(k)) n = v[4*k +: 4];
        end
        return n;
    endfunction

    function automatic logic any_bad(input logic [4*DIGITS_NUM-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS_NUM; k++) begin
            if (v[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Returns {blank flag after this digit, ASCII character}; the LSD is never blanked.
    function automatic logic [8:0] encode(input logic [3:0] d, input logic blank, input logic is_lsd);
        if (d > 4'd9)                            return {1'b0, 8'h3F};
        else if (blank && d == 4'd0 && !is_lsd)  return {1'b1, 8'h20};
        else                                     return {1'b0, 8'h30 | {4'h0, d}};
    endfunction

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        blank_d  = blank_q;
        err_d    = err_q;
        char_d   = char_q;
        valid_d  = valid_q;
        last_d   = last_q;
        next_idx = idx_q;
        nib      = '0;
        enc      = '0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    shadow_d = digits_in;
                    idx_d    = IDX_TOP;
                    nib      = pick_nibble(digits_in, IDX_TOP);
                    enc      = encode(nib, BLANK_INIT, IDX_TOP == '0);
                    char_d   = enc[7:0];
                    blank_d  = enc[8];
                    valid_d  = 1'b1;
                    last_d   = (IDX_TOP == '0);
                    err_d    = any_bad(digits_in);
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (char_ready_in) begin
                    if (idx_q == '0) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        // Encode the following digit now so it is registered with no bubble.
                        next_idx = idx_q - 1'b1;
                        idx_d    = next_idx;
                        nib      = pick_nibble(shadow_q, next_idx);
                        enc      = encode(nib, blank_q, next_idx == '0);
                        char_d   = enc[7:0];
                        blank_d  = enc[8];
                        last_d   = (next_idx == '0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            blank_q  <= 1'b0;
            err_q    <= 1'b0;
            char_q   <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign busy_out        = (state_q != IDLE);
    assign done_out        = (state_q == DONE);
    assign char_out        = char_q;
    assign char_valid_out  = valid_q;
    assign char_last_out   = last_q;
    assign digit_error_out = err_q;

endmodule

// File: tb/tb_bcd_digit_serializer.sv
// tb/tb_bcd_digit_serializer.sv - table-driven and sequence checks of bcd_digit_serializer
module tb_bcd_digit_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] digits = '0;
    logic        ready = 1'b0;

    logic [7:0] char_a, char_b, char_c, char_s;
    logic valid_a, valid_b, valid_c, valid_s;
    logic last_a, last_b, last_c, last_s;
    logic done_a, done_b, done_c, done_s;
    logic busy_a, busy_b, busy_c, busy_s;
    logic err_a, err_b, err_c, err_s;
    int   sel = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_digit_serializer #(.DIGITS_NUM(6), .BLANK_LEADING_ZEROS(1)) dut_a (
        .clk_in(clk), .reset_in(rst), .start_in(start), .digits_in(digits),
        .busy_out(busy_a), .char_out(char_a), .char_valid_out(valid_a),
        .char_ready_in(ready), .char_last_out(last_a), .done_out(done_a),
        .digit_error_out(err_a));

    bcd_digit_serializer #(.DIGITS_NUM(6), .BLANK_LEADING_ZEROS(0)) dut_b (
        .clk_in(clk), .reset_in(rst), .start_in(start), .digits_in(digits),
        .busy_out(busy_b), .char_out(char_b), .char_valid_out(valid_b),
        .char_ready_in(ready), .char_last_out(last_b), .done_out(done_b),
        .digit_error_out(err_b));

    bcd_digit_serializer #(.DIGITS_NUM(1), .BLANK_LEADING_ZEROS(1)) dut_c (
        .clk_in(clk), .reset_in(rst), .start_in(start), .digits_in(digits[3:0]),
        .busy_out(busy_c), .char_out(char_c), .char_valid_out(valid_c),
        .char_ready_in(ready), .char_last_out(last_c), .done_out(done_c),
        .digit_error_out(err_c));

    always_comb begin
        case (sel)
            1:       {char_s, valid_s, last_s, done_s, busy_s, err_s} = {char_b, valid_b, last_b, done_b, busy_b, err_b};
            2:       {char_s, valid_s, last_s, done_s, busy_s, err_s} = {char_c, valid_c, last_c, done_c, busy_c, err_c};
            default: {char_s, valid_s, last_s, done_s, busy_s, err_s} = {char_a, valid_a, last_a, done_a, busy_a, err_a};
        endcase
    end

    typedef struct {
        int          dut;
        logic [23:0] digits;
        int          n;
        logic [47:0] exp;
        logic        err;
        int          stall_idx;
        int          stall_len;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int got_n, cyc, stall_cnt;
        logic stalling;
        logic [7:0] exp_c;
        sel = v.dut;
        digits = v.digits;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_at_start", err_s, v.err);
        got_n = 0; cyc = 0; stall_cnt = 0;
        while (cyc < 40) begin
            if (done_s) break;
            exp_c = 8'(v.exp >> (8 * (5 - got_n)));
            stalling = (got_n == v.stall_idx) && (stall_cnt < v.stall_len);
            ready = !stalling;
            if (stalling) begin
                chk("stall_valid", valid_s, 1'b1);
                chk("stall_char", char_s, exp_c);
                stall_cnt++;
            end else if (valid_s) begin
                if (got_n < v.n) begin
                    chk("char", char_s, exp_c);
                    chk("last", last_s, got_n == v.n - 1);
                    chk("busy", busy_s, 1'b1);
                end else begin
                    chk("extra_char", got_n, v.n - 1);
                end
                got_n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ready = 1'b1;
        chk("done_pulse", done_s, 1'b1);
        chk("char_count", got_n, v.n);
        chk("cycles", cyc, v.n + v.stall_len);
        chk("busy_in_done", busy_s, 1'b1);
        chk("valid_in_done", valid_s, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", done_s, 1'b0);
        chk("busy_after", busy_s, 1'b0);
        chk("err_hold", err_s, v.err);
    endtask

    initial begin
        int cnt, cyc;
        logic seen_done;

        vecs[0] = '{0, 24'h001234, 6, 48'h2020_3132_3334, 1'b0, -1, 0};
        vecs[1] = '{0, 24'h000000, 6, 48'h2020_2020_2030, 1'b0, -1, 0};
        vecs[2] = '{0, 24'h987654, 6, 48'h3938_3736_3534, 1'b0,  1, 3};
        vecs[3] = '{0, 24'h0A0105, 6, 48'h203F_3031_3035, 1'b1, -1, 0};
        vecs[4] = '{1, 24'h000042, 6, 48'h3030_3030_3432, 1'b0, -1, 0};
        vecs[5] = '{0, 24'h100000, 6, 48'h3130_3030_3030, 1'b0,  3, 2};
        vecs[6] = '{2, 24'h000000, 1, 48'h3000_0000_0000, 1'b0, -1, 0};
        vecs[7] = '{2, 24'h000007, 1, 48'h3700_0000_0000, 1'b0,  0, 2};
        vecs[8] = '{2, 24'h00000B, 1, 48'h3F00_0000_0000, 1'b1, -1, 0};

        #12;
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_char", char_a, 8'h00);
        chk("rst_last", last_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Start while busy must be ignored and digits_in must not be resampled.
        sel = 0;
        digits = 24'h222222;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0; cyc = 0; seen_done = 1'b0;
        while (cyc < 20) begin
            if (done_a) begin
                seen_done = 1'b1;
                break;
            end
            if (valid_a) begin
                chk("busy_start_char", char_a, 8'h32);
                cnt++;
            end
            start = (cyc == 1);
            if (cyc == 1) digits = 24'h111111;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("busy_start_done", seen_done, 1'b1);
        chk("busy_start_count", cnt, 6);
        @(posedge clk); #1;
        chk("busy_start_idle", busy_a, 1'b0);

        // Asynchronous reset in the middle of a stream.
        digits = 24'h222222;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", valid_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", valid_a, 1'b0);
        chk("async_busy", busy_a, 1'b0);
        chk("async_last", last_a, 1'b0);
        chk("async_char", char_a, 8'h00);
        chk("async_done", done_a, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_done", done_a, 1'b0);
            chk("post_rst_busy", busy_a, 1'b0);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_digit_serializer.md
Name: bcd_digit_serializer

Overview:
- Takes a snapshot of an N-digit packed-BCD value, such as the output of the frequency counter chain, and streams it out one ASCII character at a time, most significant digit first.
- Output goes over a valid/ready handshake to the SSD1306 text/glyph renderer.
- Optionally blanks leading zeros to spaces, so the display shows a fixed-width, right-aligned number.

Parameters:
- DIGITS_NUM, 6: number of BCD digits captured and emitted; must be ≥1.
- BLANK_LEADING_ZEROS, 1: 1 replaces leading zeros with spaces; 0 emits every digit as-is.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- start_in  input  1  single-cycle request to capture digits_in and begin streaming.
- digits_in  input  4*DIGITS_NUM  packed BCD value; digit k sits at [4k+3:4k], and digit 0 is the LSD.
- busy_out  output  1  high from the cycle after an accepted start through the done_out cycle.
- char_out  output  8  ASCII character currently offered.
- char_valid_out  output  1  char_out is valid.
- char_ready_in  input  1  consumer accepts char_out when this and char_valid_out are both high.
- char_last_out  output  1  high together with char_valid_out on the final (LSD) character.
- done_out  output  1  one-cycle pulse after the last character is accepted.
- digit_error_out  output  1  sticky flag: the captured value held a non-BCD nibble (>9).

Behaviour:
- Reset (asynchronous) forces:
  - state to IDLE;
  - busy_out, char_valid_out, char_last_out, done_out and digit_error_out to 0;
  - char_out to 0x00;
  - the internal shadow register and digit index to 0.
- States are IDLE, EMIT, DONE.
- IDLE:
  - start_in=1 captures digits_in into the shadow register at that edge.
  - The digit index is set to DIGITS_NUM-1 and a blanking flag is set to BLANK_LEADING_ZEROS.
  - digit_error_out is set to 1 if any captured nibble is >9, otherwise cleared.
  - The next state is EMIT.
- Latency from start:
  - Start sampled at edge N.
  - From edge N onward, char_valid_out=1, busy_out=1 and the first character is on char_out.
- EMIT, character encoding for the current digit d:
  - d>9: emit 0x3F ('?') and clear the blanking flag.
  - Else if the blanking flag is 1, d==0 and the index is not 0: emit 0x20 (space).
  - Otherwise: emit 0x30+d and clear the blanking flag.
  - The LSD is always printed, so an all-zero value shows as a single '0'.
- EMIT, handshake:
  - The transfer happens on an edge where char_valid_out and char_ready_in are both 1.
  - While char_ready_in=0, char_out, char_valid_out and char_last_out are held stable; they are registered outputs with no combinational path from char_ready_in.
  - On a transfer with index>0: the index is decremented and the next character appears the following cycle.
  - There are no bubbles: with char_ready_in held at 1, one character transfers per cycle, so the string takes DIGITS_NUM cycles.
  - char_last_out=1 exactly while index==0.
- EMIT → DONE: on transfer of the index-0 character, char_valid_out and char_last_out drop to 0.
- DONE:
  - done_out=1 and busy_out=1 for exactly one cycle, then IDLE.
  - A new start is accepted in IDLE only, i.e. the cycle after done_out at the earliest.
- start_in while in EMIT or DONE is ignored and has no side effects.
- digits_in is only sampled at an accepted start; later changes do not affect the stream in progress.
- reset_in asserted mid-stream aborts at once:
  - all outputs reach their reset values asynchronously;
  - no done_out pulse is generated.
- digit_error_out holds its value until the next accepted start or reset.
- DIGITS_NUM=1: the single character is emitted with char_last_out=1 from the first cycle; the blanking flag has no effect.

Test Plan:
1. Basic stream: DIGITS_NUM=6, BLANK=1, digits_in=0x001234, start for 1 cycle, ready held 1.
   - Required: chars 0x20,0x20,0x31,0x32,0x33,0x34 on 6 consecutive cycles.
   - char_last_out on the 6th only.
   - done_out the cycle after; busy_out low the cycle after that.
2. All zero: digits_in=0x000000.
   - Required: five 0x20 followed by 0x30 (with char_last_out).
   - digit_error_out=0.
3. Backpressure: digits_in=0x987654, char_ready_in=0 for 3 cycles while the 2nd char (0x38) is offered.
   - Required: 0x38 held stable with valid=1 for all 3 cycles.
   - Full sequence is "987654" with nothing lost or duplicated.
4. Invalid nibble: digits_in=0x0A0105.
   - Required: 0x20,0x3F,0x30,0x31,0x30,0x35 (zeros after '?' are not blanked).
   - digit_error_out=1 from the start edge until the next start.
5. Start while busy, then reset:
   - Pulse start with 0x111111 while streaming 0x222222. Required: it is ignored and the stream stays "222222".
   - Then assert reset_in mid-stream. Required: valid, busy and last drop immediately, and done_out is never pulsed.
6. BLANK_LEADING_ZEROS=0: digits_in=0x000042.
   - Required: 0x30,0x30,0x30,0x30,0x34,0x32.
